// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate-stage self-test sequencer.
// Holds the sequencer state encoding, the gate bit positions inside the
// 7-bit gate word, the vector count and a small popcount helper.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int GATE_AND  = 0;
  localparam int GATE_OR   = 1;
  localparam int GATE_NOTA = 2;
  localparam int GATE_NAND = 3;
  localparam int GATE_NOR  = 4;
  localparam int GATE_XOR  = 5;
  localparam int GATE_XNOR = 6;

  localparam int NUM_GATES = 7;
  localparam int NUM_VEC   = 4;

  // Number of set bits in a gate word; used to count mismatching gates.
  function automatic logic [4:0] popcount7(input logic [6:0] word);
    logic [4:0] total;
    total = 5'd0;
    for (int i = 0; i < NUM_GATES; i++) begin
      total = total + {4'd0, word[i]};
    end
    return total;
  endfunction

endpackage

// File: rtl/gate_golden_model.sv
// Combinational truth table of the two-input gate stage.
// Produces the expected 7-bit gate word for a given a/b pair, in the same
// bit order as the gate stage outputs.
module gate_golden_model
  import gate_chk_pkg::*;
(
  input  logic       a,
  input  logic       b,
  output logic [6:0] expected
);

  // One bit per gate, positioned by the shared gate index constants.
  always_comb begin
    expected            = 7'd0;
    expected[GATE_AND]  = a & b;
    expected[GATE_OR]   = a | b;
    expected[GATE_NOTA] = ~a;
    expected[GATE_NAND] = ~(a & b);
    expected[GATE_NOR]  = ~(a | b);
    expected[GATE_XOR]  = a ^ b;
    expected[GATE_XNOR] = ~(a ^ b);
  end

endmodule

// File: rtl/gate_selftest_seq.sv
// Self-test sequencer for the two-input gate stage.
// Walks a/b through 00,01,10,11, waits SETTLE_CYCLES after each change,
// compares the returned gate word with the golden truth table and reports
// pass plus per-gate and per-vector failure masks.
// Optional feature macro: GATE_CHK_ERRCNT_EN adds the err_count port, a
// 5-bit total of mismatching (vector, gate) pairs (max 28, never saturates).
module gate_selftest_seq
  import gate_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic [6:0] gate_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [6:0] fail_mask,
`ifdef GATE_CHK_ERRCNT_EN
  output logic [4:0] err_count,
`endif
  output logic [3:0] fail_vec
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [1:0] LAST_VEC    = 2'(NUM_VEC - 1);

  state_t     state;
  logic [1:0] vec;
  logic [1:0] vec_next;
  logic [3:0] settle_cnt;
  logic [6:0] expected;
  logic [6:0] mismatch;
  logic [6:0] mask_next;

  // The golden word follows the registered a/b, so it always matches the
  // vector currently presented to the gate stage.
  gate_golden_model u_golden (
    .a        (a),
    .b        (b),
    .expected (expected)
  );

  // Per-sample comparison terms used by the sequencer below.
  always_comb begin
    mismatch  = gate_in ^ expected;
    mask_next = fail_mask | mismatch;
    vec_next  = vec + 2'd1;
  end

  // Sequencer: all outputs are registered and change only on state moves.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      vec        <= 2'd0;
      settle_cnt <= 4'd0;
      a          <= 1'b0;
      b          <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_mask  <= 7'd0;
      fail_vec   <= 4'd0;
`ifdef GATE_CHK_ERRCNT_EN
      err_count  <= 5'd0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            vec        <= 2'd0;
            a          <= 1'b0;
            b          <= 1'b0;
            settle_cnt <= 4'd0;
            fail_mask  <= 7'd0;
            fail_vec   <= 4'd0;
            pass       <= 1'b0;
`ifdef GATE_CHK_ERRCNT_EN
            err_count  <= 5'd0;
`endif
            busy       <= 1'b1;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= ST_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        ST_SAMPLE: begin
          fail_mask <= mask_next;
          if (|mismatch) begin
            fail_vec[vec] <= 1'b1;
          end
`ifdef GATE_CHK_ERRCNT_EN
          err_count <= err_count + popcount7(mismatch);
`endif
          if (vec == LAST_VEC) begin
            done  <= 1'b1;
            pass  <= (mask_next == 7'd0);
            state <= ST_DONE;
          end else begin
            vec        <= vec_next;
            a          <= vec_next[1];
            b          <= vec_next[0];
            settle_cnt <= 4'd0;
            state      <= ST_SETTLE;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_selftest_seq.sv
// Bench for gate_selftest_seq.
// A behavioural gate stage (truth table plus injectable corruption) feeds
// the main instance; a second instance with SETTLE_CYCLES=3 sees a gate
// stage delayed by two registers. Expected results come from a per-vector
// reference model of the applied words.
module tb_gate_selftest_seq;

  localparam logic [6:0] TRUTH_TAB [4] = '{7'h5C, 7'h2E, 7'h2A, 7'h43};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       a, b;
  logic [6:0] gate_in;
  logic       busy, done, pass;
  logic [6:0] fail_mask;
  logic [3:0] fail_vec;
`ifdef GATE_CHK_ERRCNT_EN
  logic [4:0] err_count;
  logic [4:0] err_count2;
`endif

  logic       start2;
  logic       a2, b2;
  logic [6:0] gate_in2;
  logic       busy2, done2, pass2;
  logic [6:0] fail_mask2;
  logic [3:0] fail_vec2;
  logic [6:0] dly1, dly2;

  logic [6:0] corrupt [4];
  logic [6:0] force_and;
  logic [6:0] force_or;

  logic [6:0] exp_mask;
  logic [3:0] exp_vec;
  int         exp_err;
  logic       exp_pass;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Behavioural gate stage with per-vector corruption and stuck-bit forcing.
  assign gate_in = ((TRUTH_TAB[{a, b}] ^ corrupt[{a, b}]) & force_and) | force_or;

  // Two-register-deep gate stage for the slow-settle instance.
  always @(posedge clk) begin
    dly1 <= TRUTH_TAB[{a2, b2}];
    dly2 <= dly1;
  end
  assign gate_in2 = dly2;

  gate_selftest_seq #(.SETTLE_CYCLES(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .gate_in   (gate_in),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_mask (fail_mask),
`ifdef GATE_CHK_ERRCNT_EN
    .err_count (err_count),
`endif
    .fail_vec  (fail_vec)
  );

  gate_selftest_seq #(.SETTLE_CYCLES(3)) dut_slow (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start2),
    .a         (a2),
    .b         (b2),
    .gate_in   (gate_in2),
    .busy      (busy2),
    .done      (done2),
    .pass      (pass2),
    .fail_mask (fail_mask2),
`ifdef GATE_CHK_ERRCNT_EN
    .err_count (err_count2),
`endif
    .fail_vec  (fail_vec2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: what the gate stage will return per vector versus truth.
  task automatic computeModel();
    logic [6:0] diff;
    exp_mask = 7'd0;
    exp_vec  = 4'd0;
    exp_err  = 0;
    for (int v = 0; v < 4; v++) begin
      diff = (((TRUTH_TAB[v] ^ corrupt[v]) & force_and) | force_or) ^ TRUTH_TAB[v];
      exp_mask = exp_mask | diff;
      if (diff != 7'd0) exp_vec[v] = 1'b1;
      exp_err += $countones(diff);
    end
    exp_pass = (exp_mask == 7'd0);
  endtask

  task automatic checkResults(input string tag);
    checkOutput({tag, " pass"}, 32'(pass), 32'(exp_pass));
    checkOutput({tag, " fail_mask"}, 32'(fail_mask), 32'(exp_mask));
    checkOutput({tag, " fail_vec"}, 32'(fail_vec), 32'(exp_vec));
`ifdef GATE_CHK_ERRCNT_EN
    checkOutput({tag, " err_count"}, 32'(err_count), 32'(exp_err));
`endif
  endtask

  // One run of the main instance; optional start pulses mid-run and into DONE.
  task automatic applyStimulus(input string tag, input bit pulse_mid);
    int lat;
    bit seq_ok;
    computeModel();
    seq_ok = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (lat < 200) begin
      if (lat < 8 && {a, b} !== 2'(lat / 2)) seq_ok = 1'b0;
      start = pulse_mid && (lat == 3 || lat == 7);
      @(posedge clk); #1;
      lat++;
      if (done === 1'b1) break;
    end
    checkOutput({tag, " ab_sequence"}, 32'(seq_ok), 32'd1);
    checkOutput({tag, " done_latency"}, 32'(lat), 32'd8);
    checkResults(tag);
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput({tag, " done_one_cycle"}, 32'(done), 32'd0);
    @(posedge clk); #1;
    checkOutput({tag, " idle_after"}, 32'(busy), 32'd0);
    checkResults({tag, " hold"});
  endtask

  initial begin
    int lat;
    int gap;
    bit saw_done;
    rst_n     = 1'b0;
    start     = 1'b0;
    start2    = 1'b0;
    force_and = 7'h7F;
    force_or  = 7'h00;
    for (int v = 0; v < 4; v++) corrupt[v] = 7'd0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset a", 32'(a), 32'd0);
    checkOutput("reset b", 32'(b), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset pass", 32'(pass), 32'd0);
    checkOutput("reset fail_mask", 32'(fail_mask), 32'd0);
    checkOutput("reset fail_vec", 32'(fail_vec), 32'd0);
`ifdef GATE_CHK_ERRCNT_EN
    checkOutput("reset err_count", 32'(err_count), 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus("clean", 1'b0);

    force_and = 7'h5F;
    applyStimulus("xor_stuck0", 1'b0);
    checkOutput("xor_stuck0 vec_const", 32'(fail_vec), 32'h6);

    force_and = 7'h7F;
    force_or  = 7'h7F;
    applyStimulus("all_ones", 1'b0);
`ifdef GATE_CHK_ERRCNT_EN
    checkOutput("all_ones err_const", 32'(err_count), 32'd14);
`endif
    force_or = 7'h00;

    for (int r = 0; r < 6; r++) begin
      for (int v = 0; v < 4; v++)
        corrupt[v] = ($urandom_range(0, 2) == 0) ? 7'd0 : 7'($urandom);
      if (r == 2) for (int v = 0; v < 4; v++) corrupt[v] = 7'd0;
      applyStimulus($sformatf("random%0d", r), 1'b0);
    end

    for (int v = 0; v < 4; v++) corrupt[v] = 7'($urandom);
    applyStimulus("mid_start", 1'b1);
    for (int v = 0; v < 4; v++) corrupt[v] = 7'd0;

    // Abort a run while vector 2 is settling.
    force_or = 7'h7F;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("pre_abort a", 32'(a), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort a", 32'(a), 32'd0);
    checkOutput("abort b", 32'(b), 32'd0);
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort done", 32'(done), 32'd0);
    checkOutput("abort pass", 32'(pass), 32'd0);
    checkOutput("abort fail_mask", 32'(fail_mask), 32'd0);
    checkOutput("abort fail_vec", 32'(fail_vec), 32'd0);
`ifdef GATE_CHK_ERRCNT_EN
    checkOutput("abort err_count", 32'(err_count), 32'd0);
`endif
    rst_n = 1'b1;
    force_or = 7'h00;
    saw_done = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    checkOutput("abort no_done", 32'(saw_done), 32'd0);
    checkOutput("abort stays_idle", 32'(busy), 32'd0);
    applyStimulus("after_abort", 1'b0);

    // Continuous start: done repeats every 4*(1+1)+2 cycles.
    start = 1'b1;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (done === 1'b1) break;
    end
    checkOutput("held first_done", 32'(done), 32'd1);
    for (int k = 0; k < 3; k++) begin
      gap = 0;
      while (gap < 40) begin
        @(posedge clk); #1;
        gap++;
        if (done === 1'b1) break;
      end
      checkOutput($sformatf("held period%0d", k), 32'(gap), 32'd10);
    end
    start = 1'b0;
    lat = 0;
    while (lat < 40 && busy !== 1'b0) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("held release_idle", 32'(busy), 32'd0);
    checkOutput("held pass", 32'(pass), 32'd1);

    // Slow-settle instance with a two-register gate stage.
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    lat = 0;
    while (lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (done2 === 1'b1) break;
    end
    checkOutput("slow done_latency", 32'(lat), 32'd16);
    checkOutput("slow pass", 32'(pass2), 32'd1);
    checkOutput("slow fail_mask", 32'(fail_mask2), 32'd0);
    checkOutput("slow fail_vec", 32'(fail_vec2), 32'd0);
`ifdef GATE_CHK_ERRCNT_EN
    checkOutput("slow err_count", 32'(err_count2), 32'd0);
`endif
    @(posedge clk); #1;
    checkOutput("slow idle_after", 32'(busy2), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
